// File: rtl/fir_pkg.sv
// Shared definitions for the serial FIR: controller state encoding and the
// output saturation helper used when narrowing the accumulator.
package fir_pkg;

    // Controller states. busy is derived as (state != ST_IDLE).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } fir_state_t;

    // Working width of the saturation helper. Callers sign-extend their
    // value into this width, so it must be at least the accumulator width.
    localparam int SAT_MAXW = 128;

    // Clamp a signed value to the range of a w-bit signed number,
    // [-2^(w-1), 2^(w-1)-1]. In-range values pass through unchanged.
    function automatic logic signed [SAT_MAXW-1:0] saturate(
        input logic signed [SAT_MAXW-1:0] v,
        input int                         w
    );
        logic signed [SAT_MAXW-1:0] one;
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        one    = '0;
        one[0] = 1'b1;
        hi     = (one <<< (w - 1)) - one;
        lo     = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/fir_coef_ram.sv
// Coefficient register file: one synchronous write port, one asynchronous
// read port. Writes to addresses at or above TAPS are ignored. A read of a
// tap written on the same edge returns the value held before that edge.
module fir_coef_ram #(
    parameter  int W    = 16,
    parameter  int TAPS = 8,
    localparam int AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [TAPS];
    logic         w_in_range;

    assign w_in_range = ({1'b0, i_waddr} < (AW + 1)'(TAPS));
    assign o_rdata    = r_mem[i_raddr];

    // Coefficient storage: cleared on reset, written only for valid taps.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && w_in_range) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

endmodule

// File: rtl/serial_fir.sv
// Serial (one multiply per cycle) FIR filter. A sample accepted in IDLE is
// shifted into the delay line, then TAPS MAC cycles accumulate
// d[k]*c[k] at full precision, and the DONE cycle rescales and saturates
// the sum into Y with a one-cycle y_valid pulse.
//
// Handshake: en is a strobe with X valid in the same cycle. It is accepted
// only when busy is low (IDLE); en while busy drops the sample and pulses
// overrun for one cycle. No back-pressure beyond that.
module serial_fir
    import fir_pkg::*;
#(
    parameter  int W    = 16,
    parameter  int TAPS = 8,
    localparam int AW   = $clog2(TAPS),
    localparam int ACCW = 2 * W + AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [W-1:0]  X,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [W-1:0]  coef_data,
    output logic [W-1:0]  Y,
    output logic          y_valid,
    output logic          busy,
    output logic          overrun
);

    localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

    fir_state_t              r_state;
    logic signed [W-1:0]     r_d [TAPS];
    logic        [AW-1:0]    r_k;
    logic signed [ACCW-1:0]  r_acc;
    logic        [W-1:0]     r_y;
    logic                    r_y_valid;
    logic                    r_overrun;

    logic                    w_accept;
    logic signed [W-1:0]     w_tap;
    logic signed [W-1:0]     w_coef;
    logic signed [2*W-1:0]   w_prod;
    logic signed [ACCW-1:0]  w_prod_ext;
    logic signed [ACCW-1:0]  w_shifted;
    logic signed [SAT_MAXW-1:0] w_sat_in;
    logic signed [SAT_MAXW-1:0] w_sat;
    logic                    w_unused_sat_hi;

    assign busy     = (r_state != ST_IDLE);
    assign w_accept = en && (r_state == ST_IDLE);
    assign Y        = r_y;
    assign y_valid  = r_y_valid;
    assign overrun  = r_overrun;

    fir_coef_ram #(
        .W    (W),
        .TAPS (TAPS)
    ) u_coef_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (coef_we),
        .i_waddr (coef_addr),
        .i_wdata (coef_data),
        .i_raddr (r_k),
        .o_rdata (w_coef)
    );

    // The single W x W multiplier, fed by the tap selected by r_k.
    always_comb begin
        w_tap      = r_d[r_k];
        w_prod     = w_tap * w_coef;
        w_prod_ext = {{AW{w_prod[2*W-1]}}, w_prod};
    end

    // Rescale Q2.(2W-2) sum back to Q1.(W-1) (floor) and clamp to W bits.
    always_comb begin
        w_shifted       = r_acc >>> (W - 1);
        w_sat_in        = {{(SAT_MAXW - ACCW){w_shifted[ACCW-1]}}, w_shifted};
        w_sat           = saturate(w_sat_in, W);
        w_unused_sat_hi = ^w_sat[SAT_MAXW-1:W];
    end

    // Delay line: shifts only when a sample is accepted, so dropped
    // samples never disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_d[i] <= '0;
            end
        end else if (w_accept) begin
            r_d[0] <= X;
            for (int i = 1; i < TAPS; i++) begin
                r_d[i] <= r_d[i-1];
            end
        end
    end

    // Controller: IDLE -> MAC (TAPS cycles) -> DONE -> IDLE, with the
    // accumulator and tap counter advancing in MAC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_k     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_k   <= r_k + AW'(1);
                    if (r_k == K_LAST) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register and status pulses; Y holds between updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_y_valid <= 1'b0;
            r_overrun <= en && (r_state != ST_IDLE);
            if (r_state == ST_DONE) begin
                r_y       <= w_sat[W-1:0];
                r_y_valid <= 1'b1;
            end
        end
    end

endmodule
